uart_tx_mmio: RTL

Memory-mapped UART transmitter peripheral on the SoC data bus, downstream of the CPU store path and beside the `led` output register. The CPU writes bytes into a small FIFO. The block serialises them as 8N1 frames on the `tx` pin. Software polls a status register for busy, full, empty and overflow. It is the first off-chip debug output after the LEDs and is sized for simple 200-to-few-thousand-cycle simulations as well as the board.

---
 rtl/uart_tx_mmio_if.sv | 12 +
 rtl/uart_tx_mmio.sv | 128 ++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio_if.sv
// Bus access interface for the memory-mapped UART transmitter.
// The CPU side is the master and the peripheral side is the slave.
interface uart_tx_mmio_if;
  logic        bus_en;
  logic        bus_we;
  logic        bus_addr;
  logic [7:0]  bus_wdata;
  logic [31:0] bus_rdata;

  modport master (output bus_en, bus_we, bus_addr, bus_wdata, input bus_rdata);
  modport slave  (input bus_en, bus_we, bus_addr, bus_wdata, output bus_rdata);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO and a polled status register.
// STATUS = {28'b0, overflow, empty, full, busy}; DATA writes enqueue bytes for transmission.
module uart_tx_mmio #(
  parameter int CLK_DIV    = 104,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            resetn,
  uart_tx_mmio_if.slave   bus,
  output logic            tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          overflow;

  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic full, empty, busy, data_wr, status_rd, push, pop;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign busy      = (state != IDLE) || !empty;
  assign data_wr   = bus.bus_en && bus.bus_we && !bus.bus_addr;
  assign status_rd = bus.bus_en && !bus.bus_we && bus.bus_addr;
  // Full is judged on the pre-edge count, so a same-cycle pop never rescues a push.
  assign push      = data_wr && !full;
  assign pop       = !empty && ((state == IDLE) || ((state == STOP) && (baud == BAUD_LAST)));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.bus_wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      overflow      <= 1'b0;
      bus.bus_rdata <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (data_wr && full) overflow <= 1'b1;
      else if (status_rd)  overflow <= 1'b0;
      if (bus.bus_en && !bus.bus_we)
        bus.bus_rdata <= bus.bus_addr ? {28'b0, overflow, empty, full, busy} : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      tx      <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift <= mem[rd_ptr];
            tx    <= 1'b0;
            baud  <= '0;
            state <= START;
          end
        end
        START: begin
          if (baud == BAUD_LAST) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            // Chain straight into the next start bit when more data is queued.
            if (pop) begin
              shift <= mem[rd_ptr];
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
